wb_forward_source: RTL and testbench

- Producer side of operand forwarding: owns the EX/MEM and MEM/WB destination-tracking registers.
- Presents, per stage, the destination address, valid flag and value that the decode-side forwarding selector compares against and muxes from.
- Drives the register-file write port.
- Detects load-use hazards and memory-wait freezes, and generates the corresponding stall/hold signals to the front end.

---
 rtl/wb_forward_source.sv | 150 +++++++++++++++
 tb/tb_wb_forward_source.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_forward_source.sv
// -----------------------------------------------------------------------------
// wb_forward_source
//
// Producer side of operand forwarding. Owns the EX/MEM and MEM/WB
// destination-tracking registers, presents each slot's address/valid/value to
// the decode-side forwarding selector, drives the register-file write port and
// raises the load-use and memory-wait stall signals toward the front end.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   ex_*                instruction currently in EX (write enable, load flag,
//                       destination, ALU result)
//   dec_*               source/destination-as-source addresses read by the
//                       instruction in decode, with their use flags
//   flush               discard the instruction entering EX/MEM
//   mem_ready/mem_rdata load data return from data memory
//   exmem_*             EX/MEM slot as seen by the forwarding selector
//   memwb_*             MEM/WB slot as seen by the forwarding selector
//   rf_*                register-file write port (straight from MEM/WB)
//   load_use_stall      hold decode/fetch, bubble into EX
//   mem_wait            hold whole front end while a load waits on memory
//   stall_count         saturating count of stalled cycles
//
// Handshake: a load sitting in EX/MEM completes on the first rising edge at
// which mem_ready is high; mem_rdata is only sampled on that edge. While
// mem_ready is low the load is held in EX/MEM and MEM/WB receives a bubble.
// Consumers must qualify every address match with the matching *_valid flag.
// -----------------------------------------------------------------------------
module wb_forward_source #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_wb_en,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_rdst,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] dec_rsrc,
    input  logic [ADDR_W-1:0] dec_rdst,
    input  logic              dec_uses_rsrc,
    input  logic              dec_uses_rdst,
    input  logic              flush,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              exmem_valid,
    output logic [ADDR_W-1:0] exmem_addr,
    output logic [DATA_W-1:0] exmem_data,
    output logic              exmem_is_load,
    output logic              memwb_valid,
    output logic [ADDR_W-1:0] memwb_addr,
    output logic [DATA_W-1:0] memwb_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              load_use_stall,
    output logic              mem_wait,
    output logic [CNT_W-1:0]  stall_count
);

    logic              r_exmem_valid;
    logic              r_exmem_is_load;
    logic [ADDR_W-1:0] r_exmem_addr;
    logic [DATA_W-1:0] r_exmem_data;
    logic              r_memwb_valid;
    logic [ADDR_W-1:0] r_memwb_addr;
    logic [DATA_W-1:0] r_memwb_data;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_mem_wait;
    logic              w_src_hit;
    logic              w_dst_hit;
    logic              w_load_use;
    logic              w_stall_any;
    logic              w_cnt_sat;

    // A load in EX/MEM with no data yet freezes the pipe.
    assign w_mem_wait = r_exmem_valid & r_exmem_is_load & ~mem_ready;

    assign w_src_hit  = dec_uses_rsrc & (dec_rsrc == ex_rdst);
    assign w_dst_hit  = dec_uses_rdst & (dec_rdst == ex_rdst);

    // Suppressed during mem_wait: the whole front end is already held, so a
    // bubble into EX would be redundant.
    assign w_load_use = ex_wb_en & ex_is_load & ~w_mem_wait & (w_src_hit | w_dst_hit);

    assign w_stall_any = w_load_use | w_mem_wait;
    assign w_cnt_sat   = &r_stall_count;

    // EX/MEM: hold beats flush, flush beats normal advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exmem_valid   <= 1'b0;
            r_exmem_is_load <= 1'b0;
            r_exmem_addr    <= '0;
            r_exmem_data    <= '0;
        end else if (w_mem_wait) begin
            r_exmem_valid   <= r_exmem_valid;
            r_exmem_is_load <= r_exmem_is_load;
        end else if (flush) begin
            // Address/data are meaningless once valid drops; leave them.
            r_exmem_valid   <= 1'b0;
            r_exmem_is_load <= 1'b0;
        end else begin
            r_exmem_valid   <= ex_wb_en;
            r_exmem_is_load <= ex_is_load & ex_wb_en;
            r_exmem_addr    <= ex_rdst;
            r_exmem_data    <= ex_result;
        end
    end

    // MEM/WB: bubble while waiting on memory; flush never reaches here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_memwb_valid <= 1'b0;
            r_memwb_addr  <= '0;
            r_memwb_data  <= '0;
        end else if (w_mem_wait) begin
            r_memwb_valid <= 1'b0;
        end else begin
            r_memwb_valid <= r_exmem_valid;
            r_memwb_addr  <= r_exmem_addr;
            r_memwb_data  <= r_exmem_is_load ? mem_rdata : r_exmem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (w_stall_any && !w_cnt_sat) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign exmem_valid    = r_exmem_valid;
    assign exmem_addr     = r_exmem_addr;
    assign exmem_data     = r_exmem_data;
    assign exmem_is_load  = r_exmem_is_load;
    assign memwb_valid    = r_memwb_valid;
    assign memwb_addr     = r_memwb_addr;
    assign memwb_data     = r_memwb_data;
    assign rf_we          = r_memwb_valid;
    assign rf_waddr       = r_memwb_addr;
    assign rf_wdata       = r_memwb_data;
    assign load_use_stall = w_load_use;
    assign mem_wait       = w_mem_wait;
    assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_wb_forward_source.sv
module tb_wb_forward_source;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 3;   // narrow so saturation is reachable quickly

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              ex_wb_en = 1'b0;
  logic              ex_is_load = 1'b0;
  logic [ADDR_W-1:0] ex_rdst = '0;
  logic [DATA_W-1:0] ex_result = '0;
  logic [ADDR_W-1:0] dec_rsrc = '0;
  logic [ADDR_W-1:0] dec_rdst = '0;
  logic              dec_uses_rsrc = 1'b0;
  logic              dec_uses_rdst = 1'b0;
  logic              flush = 1'b0;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic              exmem_valid;
  logic [ADDR_W-1:0] exmem_addr;
  logic [DATA_W-1:0] exmem_data;
  logic              exmem_is_load;
  logic              memwb_valid;
  logic [ADDR_W-1:0] memwb_addr;
  logic [DATA_W-1:0] memwb_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              load_use_stall;
  logic              mem_wait;
  logic [CNT_W-1:0]  stall_count;

  wb_forward_source #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_wb_en       (ex_wb_en),
    .ex_is_load     (ex_is_load),
    .ex_rdst        (ex_rdst),
    .ex_result      (ex_result),
    .dec_rsrc       (dec_rsrc),
    .dec_rdst       (dec_rdst),
    .dec_uses_rsrc  (dec_uses_rsrc),
    .dec_uses_rdst  (dec_uses_rdst),
    .flush          (flush),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .exmem_valid    (exmem_valid),
    .exmem_addr     (exmem_addr),
    .exmem_data     (exmem_data),
    .exmem_is_load  (exmem_is_load),
    .memwb_valid    (memwb_valid),
    .memwb_addr     (memwb_addr),
    .memwb_data     (memwb_data),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .load_use_stall (load_use_stall),
    .mem_wait       (mem_wait),
    .stall_count    (stall_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  // Advance one cycle; inputs are changed 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic wb, input logic ld,
                          input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] res);
    ex_wb_en   = wb;
    ex_is_load = ld;
    ex_rdst    = rd;
    ex_result  = res;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held with EX activity toggling: everything stays 0.
    #1;
    for (int i = 0; i < 4; i++) begin
      drive_ex(i[0], 1'b0, 3'd7, 16'hFFFF);
      tick();
    end
    #2;
    check("rst_exmem_valid", exmem_valid, 0);
    check("rst_memwb_valid", memwb_valid, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_exmem_addr", exmem_addr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_mem_wait", mem_wait, 0);
    check("rst_load_use", load_use_stall, 0);

    // First ALU write after reset.
    rst = 1'b1;
    drive_ex(1'b1, 1'b0, 3'd5, 16'h00A5);
    tick();
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    #2;
    check("alu_exmem_valid", exmem_valid, 1);
    check("alu_exmem_addr", exmem_addr, 5);
    check("alu_exmem_data", exmem_data, 16'h00A5);
    check("alu_rf_we_early", rf_we, 0);
    tick();
    #2;
    check("alu_rf_we", rf_we, 1);
    check("alu_rf_waddr", rf_waddr, 5);
    check("alu_rf_wdata", rf_wdata, 16'h00A5);

    // Back-to-back ALU ops: writes 1,2,3 on consecutive cycles.
    tick();
    drive_ex(1'b1, 1'b0, 3'd1, 16'h0011);
    tick();
    drive_ex(1'b1, 1'b0, 3'd2, 16'h0022);
    tick();
    drive_ex(1'b1, 1'b0, 3'd3, 16'h0033);
    #2;
    check("b2b_1_we", rf_we, 1);
    check("b2b_1_addr", rf_waddr, 1);
    check("b2b_1_data", rf_wdata, 16'h0011);
    tick();
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    #2;
    check("b2b_2_addr", rf_waddr, 2);
    check("b2b_2_data", rf_wdata, 16'h0022);
    tick();
    #2;
    check("b2b_3_we", rf_we, 1);
    check("b2b_3_addr", rf_waddr, 3);
    check("b2b_3_data", rf_wdata, 16'h0033);
    check("b2b_stall_count", stall_count, 0);

    // Load-use: load rdst=4 in EX, decode reads r4.
    tick();
    drive_ex(1'b1, 1'b1, 3'd4, 16'h9999);
    dec_rsrc = 3'd4;
    dec_uses_rsrc = 1'b1;
    #2;
    check("lu_stall", load_use_stall, 1);
    check("lu_no_wait", mem_wait, 0);
    tick();
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    dec_uses_rsrc = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    #2;
    check("lu_stall_one_cycle", load_use_stall, 0);
    check("lu_exmem_is_load", exmem_is_load, 1);
    check("lu_mem_wait", mem_wait, 0);
    check("lu_stall_count", stall_count, 1);
    tick();
    mem_ready = 1'b0;
    #2;
    check("lu_rf_we", rf_we, 1);
    check("lu_rf_waddr", rf_waddr, 4);
    check("lu_memwb_data", memwb_data, 16'hBEEF);

    // Fresh reset so the memory-wait stall count starts at 0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    check("rst2_stall_count", stall_count, 0);

    // Memory wait: load rdst=6, three cycles without data.
    drive_ex(1'b1, 1'b1, 3'd6, 16'h7777);
    tick();
    drive_ex(1'b1, 1'b0, 3'd1, 16'h5555);   // held in EX by the front end
    #2;
    check("mw_wait_c1", mem_wait, 1);
    tick();
    #2;
    check("mw_wait_c2", mem_wait, 1);
    check("mw_exmem_addr", exmem_addr, 6);
    check("mw_exmem_is_load", exmem_is_load, 1);
    check("mw_bubble_c2", memwb_valid, 0);
    tick();
    #2;
    check("mw_wait_c3", mem_wait, 1);
    check("mw_bubble_c3", memwb_valid, 0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    #2;
    check("mw_wait_done", mem_wait, 0);
    check("mw_bubble_c4", memwb_valid, 0);
    check("mw_stall_count", stall_count, 3);
    tick();
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    mem_ready = 1'b0;
    #2;
    check("mw_rf_we", rf_we, 1);
    check("mw_rf_waddr", rf_waddr, 6);
    check("mw_rf_wdata", rf_wdata, 16'h1234);
    check("mw_exmem_next_addr", exmem_addr, 1);
    check("mw_exmem_next_data", exmem_data, 16'h5555);

    // Flush: write to r2 squashed; no rf write two cycles later.
    drive_ex(1'b1, 1'b0, 3'd2, 16'h2222);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    #2;
    check("fl_exmem_valid", exmem_valid, 0);
    check("fl_prev_write", rf_waddr, 1);
    tick();
    #2;
    check("fl_no_rf_we", rf_we, 0);

    // Flush during mem_wait: hold wins; load/load_use overlap reports mem_wait only.
    drive_ex(1'b1, 1'b1, 3'd3, 16'h0000);
    tick();
    drive_ex(1'b1, 1'b1, 3'd7, 16'h4444);
    dec_rsrc = 3'd7;
    dec_uses_rsrc = 1'b1;
    flush = 1'b1;
    #2;
    check("flw_mem_wait", mem_wait, 1);
    check("flw_no_load_use", load_use_stall, 0);
    tick();
    flush = 1'b0;
    dec_uses_rsrc = 1'b0;
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    mem_ready = 1'b1;
    mem_rdata = 16'hABCD;
    #2;
    check("flw_exmem_valid", exmem_valid, 1);
    check("flw_exmem_addr", exmem_addr, 3);
    check("flw_exmem_is_load", exmem_is_load, 1);
    tick();
    mem_ready = 1'b0;
    #2;
    check("flw_rf_we", rf_we, 1);
    check("flw_rf_waddr", rf_waddr, 3);
    check("flw_rf_wdata", rf_wdata, 16'hABCD);

    // Invalid slot: address 0 everywhere, no write enable.
    drive_ex(1'b0, 1'b1, 3'd0, 16'h0F0F);
    dec_rsrc = 3'd0;
    dec_uses_rsrc = 1'b1;
    #2;
    check("inv_no_load_use", load_use_stall, 0);
    tick();
    dec_uses_rsrc = 1'b0;
    #2;
    check("inv_exmem_valid", exmem_valid, 0);
    check("inv_exmem_is_load", exmem_is_load, 0);
    tick();
    #2;
    check("inv_rf_we", rf_we, 0);

    // Reset mid-load: pending load discarded, no rf write afterwards.
    drive_ex(1'b1, 1'b1, 3'd2, 16'h0000);
    tick();
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    #2;
    check("rml_wait", mem_wait, 1);
    rst = 1'b0;
    #1;
    check("rml_exmem_valid", exmem_valid, 0);
    check("rml_wait_cleared", mem_wait, 0);
    tick();
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    #2;
    check("rml_no_rf_we", rf_we, 0);

    // Saturation: ten wait cycles on a 3-bit counter stop at 7.
    mem_ready = 1'b0;
    drive_ex(1'b1, 1'b1, 3'd5, 16'h0000);
    tick();
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 10; i++) tick();
    #2;
    check("sat_wait", mem_wait, 1);
    check("sat_stall_count", stall_count, 7);
    mem_ready = 1'b1;
    mem_rdata = 16'h5A5A;
    tick();
    #2;
    check("sat_rf_waddr", rf_waddr, 5);
    check("sat_rf_wdata", rf_wdata, 16'h5A5A);
    check("sat_stall_hold", stall_count, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
